// File: rtl/dcache_direct_if.sv
// ---------------------------------------------------------------------------
// dcache_direct_if
// Bus bundle for the direct-mapped data cache. It carries both sides of the
// cache: the CPU load/store handshake and the block-wide data-memory port.
//
// Signals (names follow the CPU / data-memory handshake they model):
//   READ, WRITE          CPU load / store request
//   ADDRESS[7:0]         CPU byte address
//   WRITEDATA[7:0]       CPU store data
//   READDATA[7:0]        load data back to the register file
//   BUSYWAIT             stall to the CPU
//   mem_read, mem_write  block request to data memory
//   mem_address          block address {tag,index}
//   mem_writedata[31:0]  evicted block (byte0 in [7:0])
//   mem_readdata[31:0]   fetched block
//   mem_busywait         data memory busy
//
// Modports:
//   slave  - the cache itself (serves the CPU, drives the memory requests)
//   master - the surroundings (CPU issuing accesses, memory answering)
// ---------------------------------------------------------------------------
interface dcache_direct_if #(
    parameter int MEM_ADDR_W = 6
);
    logic                  READ;
    logic                  WRITE;
    logic [7:0]            ADDRESS;
    logic [7:0]            WRITEDATA;
    logic [7:0]            READDATA;
    logic                  BUSYWAIT;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [31:0]           mem_writedata;
    logic [31:0]           mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        output READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        input  READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_direct.sv
// ---------------------------------------------------------------------------
// DcacheDirect (module dcache_direct)
// Direct-mapped, write-back data cache between the 8-bit CPU load/store port
// and the 32-bit-block data memory. Hits complete without a stall; a miss
// stalls the CPU while a dirty victim is written back and the block fetched.
//
// Ports:
//   CLK        system clock, all state changes on posedge
//   RESET      asynchronous, active-low reset
//   bus        dcache_direct_if.slave (CPU handshake + data-memory port)
//   hit_count  [15:0] saturating count of stall-free accesses (optional)
//   miss_count [15:0] saturating count of misses (optional)
//
// Optional feature: define DCACHE_STATS_EN to add hit_count / miss_count.
// ---------------------------------------------------------------------------
module dcache_direct #(
    parameter int NUM_BLOCKS = 8,
    parameter int MEM_ADDR_W = 6
) (
    input  logic           CLK,
    input  logic           RESET,
    dcache_direct_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]    hit_count,
    output logic [15:0]    miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = MEM_ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [31:0]           data_q [NUM_BLOCKS];
    logic [7:0]            readData_q;

    logic [TAG_W-1:0]      addrTag;
    logic [IDX_W-1:0]      lineIdx;
    logic [1:0]            offset;
    logic                  access;
    logic                  hit;
    logic                  writeHit;
    logic                  readHit;
    logic [7:0]            hitByte;
    logic [7:0]            readDataNow;

    assign addrTag = bus.ADDRESS[2+IDX_W +: TAG_W];
    assign lineIdx = bus.ADDRESS[2 +: IDX_W];
    assign offset  = bus.ADDRESS[1:0];

    // Lookup of the addressed line. READ together with WRITE counts as a
    // store, so only a pure load drives fresh data onto READDATA; otherwise
    // READDATA keeps showing the last load result.
    always_comb begin
        access      = bus.READ | bus.WRITE;
        hit         = valid_q[lineIdx] && (tag_q[lineIdx] == addrTag);
        writeHit    = (state_q == IDLE) && bus.WRITE && hit;
        readHit     = (state_q == IDLE) && bus.READ && !bus.WRITE && hit;
        hitByte     = data_q[lineIdx][{offset, 3'b000} +: 8];
        readDataNow = readHit ? hitByte : readData_q;
    end

    assign bus.READDATA = readDataNow;

    // Next-state and output decode of the miss handler. BUSYWAIT in IDLE is
    // qualified by RESET so the CPU is never stalled while reset is held,
    // even if it keeps a request asserted on an (now invalid) line.
    always_comb begin
        state_d           = state_q;
        bus.BUSYWAIT      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        case (state_q)
            IDLE: begin
                bus.BUSYWAIT = RESET && access && !hit;
                if (access && !hit) begin
                    if (valid_q[lineIdx] && dirty_q[lineIdx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                bus.BUSYWAIT      = 1'b1;
                bus.mem_write     = 1'b1;
                bus.mem_address   = {tag_q[lineIdx], lineIdx};
                bus.mem_writedata = data_q[lineIdx];
                if (!bus.mem_busywait) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                bus.BUSYWAIT    = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_address = {addrTag, lineIdx};
                if (!bus.mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // The refilled line is looked up again in IDLE as a hit.
                bus.BUSYWAIT = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, line status bits and the held load result.
    // Reset abandons any memory transaction simply by returning to IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            readData_q <= '0;
        end else begin
            state_q    <= state_d;
            readData_q <= readDataNow;
            if (writeHit) begin
                dirty_q[lineIdx] <= 1'b1;
            end
            if (state_q == UPDATE) begin
                valid_q[lineIdx] <= 1'b1;
                dirty_q[lineIdx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays are plain storage and survive reset; the cleared
    // valid bits make their contents irrelevant until refilled.
    always_ff @(posedge CLK) begin
        if (writeHit) begin
            data_q[lineIdx][{offset, 3'b000} +: 8] <= bus.WRITEDATA;
        end
        if (state_q == UPDATE) begin
            data_q[lineIdx] <= bus.mem_readdata;
            tag_q[lineIdx]  <= addrTag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hitCount_q;
    logic [15:0] missCount_q;
    logic        fromUpdate_q;

    // Access statistics. The IDLE cycle right after UPDATE finishes an
    // access that already stalled, so it is not counted as a hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hitCount_q   <= '0;
            missCount_q  <= '0;
            fromUpdate_q <= 1'b0;
        end else begin
            fromUpdate_q <= (state_q == UPDATE);
            if ((state_q == IDLE) && access && hit && !fromUpdate_q &&
                (hitCount_q != 16'hFFFF)) begin
                hitCount_q <= hitCount_q + 16'd1;
            end
            if ((state_q == IDLE) && (state_d != IDLE) &&
                (missCount_q != 16'hFFFF)) begin
                missCount_q <= missCount_q + 16'd1;
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// ---------------------------------------------------------------------------
// tb_dcache_direct
// Self-checking bench for dcache_direct. The bench plays the CPU and a data
// memory with fixed latency, keeps its own model of the cache contents and
// of memory, and queues the expected load data, stall lengths and memory
// transactions as each access is issued.
// ---------------------------------------------------------------------------
module tb_dcache_direct;

    localparam int LAT = 3;

    typedef struct {
        bit          isWrite;
        logic [5:0]  addr;
        logic [31:0] data;
    } memTxn_t;

    logic CLK;
    logic RESET;
    logic loadMem;

    dcache_direct_if #(.MEM_ADDR_W(6)) bus ();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_direct #(
        .NUM_BLOCKS(8),
        .MEM_ADDR_W(6)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard queues.
    memTxn_t    memQ[$];
    logic [7:0] rdQ[$];
    int         stallQ[$];

    // Reference model of the cache and of memory.
    logic [63:0] refValidDummy;
    logic [7:0]  refValid;
    logic [7:0]  refDirty;
    logic [2:0]  refTag  [8];
    logic [31:0] refData [8];
    logic [31:0] refMem  [64];
    logic [7:0]  lastRead;

    // Memory model state.
    logic [31:0] memArray [64];
    int          memCount;
    logic [7:0]  prevKey;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] initPattern(input int i);
        if (i == 1) return 32'hDDCCBBAA;
        return 32'h5A3C9618 ^ (32'(i) * 32'h01030507);
    endfunction

    // Memory answers a request after LAT busy cycles; busywait rises in the
    // same cycle the request appears.
    assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (memCount != LAT);

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            memCount <= 0;
        end else if (bus.mem_read | bus.mem_write) begin
            if (memCount == LAT) begin
                memCount <= 0;
                if (bus.mem_read) bus.mem_readdata <= memArray[bus.mem_address];
            end else begin
                memCount <= memCount + 1;
            end
        end else begin
            memCount <= 0;
        end
    end

    always @(posedge CLK) begin
        if (loadMem) begin
            for (int i = 0; i < 64; i++) memArray[i] <= initPattern(i);
        end else if (RESET && bus.mem_write && (memCount == LAT)) begin
            memArray[bus.mem_address] <= bus.mem_writedata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Every new memory request is checked against the expected transaction.
    always @(negedge CLK) begin
        logic [7:0] key;
        memTxn_t    e;
        if (RESET && (bus.mem_read || bus.mem_write)) begin
            key = {bus.mem_read, bus.mem_write, bus.mem_address};
            if (key != prevKey) begin
                if (memQ.size() == 0) begin
                    checkOutput("mem_unexpected", 32'(memQ.size()), 32'd1);
                end else begin
                    e = memQ.pop_front();
                    checkOutput("mem_kind", 32'(bus.mem_write), 32'(e.isWrite));
                    checkOutput("mem_addr", 32'(bus.mem_address), 32'(e.addr));
                    if (e.isWrite) checkOutput("mem_wdata", bus.mem_writedata, e.data);
                end
            end
            prevKey = key;
        end else begin
            prevKey = 8'h00;
        end
    end

    // Issue one CPU access (called #1 after a posedge), predict its outcome
    // from the model and compare stall length and load data.
    task automatic applyStimulus(input bit rd, input bit wr,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        logic [2:0] idx;
        logic [2:0] tg;
        int         off;
        int         stall;
        int         expStall;
        bit         hitM;
        idx = addr[4:2];
        tg  = addr[7:5];
        off = int'(addr[1:0]);
        hitM = refValid[idx] && (refTag[idx] == tg);
        expStall = 0;
        if (!hitM) begin
            if (refValid[idx] && refDirty[idx]) begin
                memQ.push_back('{1'b1, {refTag[idx], idx}, refData[idx]});
                refMem[{refTag[idx], idx}] = refData[idx];
                expStall += LAT + 1;
            end
            memQ.push_back('{1'b0, {tg, idx}, 32'h0});
            refData[idx]  = refMem[{tg, idx}];
            refTag[idx]   = tg;
            refValid[idx] = 1'b1;
            refDirty[idx] = 1'b0;
            expStall += LAT + 1 + 2;
        end
        stallQ.push_back(expStall);
        if (wr) begin
            refData[idx][off*8 +: 8] = wdata;
            refDirty[idx] = 1'b1;
        end else if (rd) begin
            rdQ.push_back(refData[idx][off*8 +: 8]);
            lastRead = refData[idx][off*8 +: 8];
        end

        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
        stall = 0;
        @(negedge CLK);
        while (bus.BUSYWAIT === 1'b1 && stall < 64) begin
            stall++;
            @(negedge CLK);
        end
        checkOutput("stall_cycles", 32'(stall), 32'(stallQ.pop_front()));
        if (rd && !wr) checkOutput("readdata", 32'(bus.READDATA), 32'(rdQ.pop_front()));
        @(posedge CLK);
        #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        int waitCount;
        RESET         = 1'b0;
        loadMem       = 1'b1;
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = 8'h00;
        bus.WRITEDATA = 8'h00;
        refValid      = '0;
        refDirty      = '0;
        refValidDummy = '0;
        lastRead      = 8'h00;
        for (int i = 0; i < 64; i++) refMem[i] = initPattern(i);

        repeat (2) @(posedge CLK);
        #1 loadMem = 1'b0;
        @(negedge CLK);
        checkOutput("rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        checkOutput("rst_readdata", 32'(bus.READDATA), 32'd0);
        checkOutput("rst_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("rst_mem_address", 32'(bus.mem_address), 32'd0);
        checkOutput("rst_mem_writedata", bus.mem_writedata, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;

        $display("[TB] cold read miss, hit, write hit, dirty eviction");
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h06, 8'h00);
        @(negedge CLK);
        checkOutput("readdata_hold", 32'(bus.READDATA), 32'(lastRead));
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h07, 8'h5A);
        applyStimulus(1'b1, 1'b0, 8'h27, 8'h00);
`ifdef DCACHE_STATS_EN
        checkOutput("hit_count", 32'(hit_count), 32'd2);
        checkOutput("miss_count", 32'(miss_count), 32'd2);
`endif

        $display("[TB] reset in the middle of a fetch");
        memQ.push_back('{1'b0, 6'h01, 32'h0});
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h05;
        waitCount   = 0;
        @(negedge CLK);
        while (bus.mem_read !== 1'b1 && waitCount < 20) begin
            waitCount++;
            @(negedge CLK);
        end
        checkOutput("fetch_started", 32'(bus.mem_read), 32'd1);
        #2 RESET = 1'b0;
        #1;
        checkOutput("midrst_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("midrst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        refValid = '0;
        refDirty = '0;
        @(posedge CLK);
        #1;
        RESET    = 1'b1;
        bus.READ = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);

        $display("[TB] READ and WRITE together on a hit");
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h12, 8'hE7);
        applyStimulus(1'b1, 1'b0, 8'h30, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h12, 8'h00);

        $display("[TB] mixed accesses");
        for (int n = 0; n < 24; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            applyStimulus(op != 1, op != 0, 8'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        end

        repeat (2) @(negedge CLK);
        checkOutput("memq_drained", 32'(memQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back data cache between the 8-bit CPU's load/store port and the 32-bit-block data memory.
- Presents the CPU the same READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake the data memory presents.
- Hits complete with no stall. Misses stall the CPU while the block is written back (if dirty) and then fetched.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of 2. Index width is log2(NUM_BLOCKS).
- MEM_ADDR_W, 6, width of the memory block address (ADDRESS[7:2]).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request (lwd/lwi).
- WRITE  in  1  CPU store request (swd/swi).
- ADDRESS  in  8  CPU byte address, split as tag[7:5], index[4:2], offset[1:0] at the defaults.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data to the register file.
- BUSYWAIT  out  1  stall to the CPU; the PC and register write are held while it is 1.
- mem_read  out  1  block read request to data memory.
- mem_write  out  1  block write request to data memory.
- mem_address  out  6  block address {tag,index} or {stored_tag,index}.
- mem_writedata  out  32  evicted block, with byte0 in bits [7:0].
- mem_readdata  in  32  fetched block.
- mem_busywait  in  1  memory busy. Memory raises it combinationally in the cycle a request appears.

Behaviour:
- Storage per line: valid, dirty, tag[2:0], data[31:0].
- hit = valid[index] && (tag[index] == ADDRESS tag).
- Reset (RESET == 0, asynchronous):
  - All valid and dirty bits clear; the FSM goes to IDLE.
  - mem_read = 0, mem_write = 0, mem_address = 0, mem_writedata = 0, BUSYWAIT = 0, READDATA = 0.
  - A memory transaction in flight is abandoned. Data arrays are not cleared.
- The FSM has four states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - BUSYWAIT = (READ | WRITE) && !hit, combinational.
  - Read hit: READDATA = the selected byte of data[index], combinational. The CPU takes it at the next posedge.
  - Write hit: at posedge, the byte at offset := WRITEDATA and dirty[index] := 1.
  - Miss on a dirty line → WRITEBACK. Miss on a clean or invalid line → FETCH.
- WRITEBACK:
  - Drives mem_write = 1, mem_address = {tag[index], index}, mem_writedata = data[index].
  - Held stable until the first posedge with mem_busywait == 0, then → FETCH.
- FETCH:
  - Drives mem_read = 1, mem_address = {ADDRESS tag, index}.
  - On the first posedge with mem_busywait == 0 → UPDATE.
- UPDATE (1 cycle):
  - data[index] := mem_readdata, tag := ADDRESS tag, valid := 1, dirty := 0.
  - mem_read and mem_write are 0. BUSYWAIT stays 1. Then → IDLE.
  - The access is re-evaluated in IDLE as a hit, so BUSYWAIT falls one cycle after UPDATE.
- READ and WRITE both high: treated as WRITE. READDATA is undefined in that cycle.
- In WRITEBACK, FETCH and UPDATE, BUSYWAIT = 1 regardless of READ/WRITE.
- READDATA holds its last value when READ == 0.
- A hit on a line just filled in UPDATE completes in IDLE with no extra stall.
- Miss penalty = memory latency (plus memory latency again if dirty) + 2 cycles.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, two extra outputs are added: hit_count[15:0] and miss_count[15:0].
  - Both are 16-bit saturating counters, cleared by RESET.
  - hit_count increments once per access completed without a stall.
  - miss_count increments once on each IDLE→WRITEBACK or IDLE→FETCH transition.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then READ at ADDRESS 0x05 → BUSYWAIT=1, FETCH with mem_address=0x01 and no WRITEBACK. After mem_readdata=0xDDCCBBAA, READDATA=0xBB and BUSYWAIT falls 1 cycle after UPDATE.
- Repeat READ at 0x06 → READDATA=0xCC in the same cycle, BUSYWAIT stays 0.
- WRITE 0x5A to 0x07, then READ at 0x27 (same index, tag differs) → WRITEBACK with mem_address=0x01, mem_writedata=0x5ACCBBAA, then FETCH with mem_address=0x09.
- Assert RESET low during FETCH → mem_read drops immediately and BUSYWAIT=0. A later READ at 0x05 misses again because valid was cleared.
- READ and WRITE both high on a hit to 0x10 → a byte write occurs, the line is marked dirty, no stall.
- With DCACHE_STATS_EN, run scenarios 1–3 → hit_count=2 (the 0x06 read and the 0x07 write), miss_count=2.
